// File: rtl/eb2a_ctrl.sv
// eb2a_ctrl -- handshake controller for the two-entry elastic buffer datapath.
//
// Turns an upstream req/ack stream and a downstream req/ack stream into the
// load enables and output select of a two-register datapath. The pair forms a
// registered-boundary, full-throughput pipeline stage. t_0_ack is a flop, so
// there is no combinational path from i_0_ack back to t_0_ack.
//
// Ports:
//   clk        in   sole clock, rising edge
//   reset      in   asynchronous active-high reset
//   t_0_req    in   upstream offers a word on the datapath input
//   t_0_ack    out  controller can accept a word (registered)
//   i_0_req    out  datapath output holds a valid word (registered)
//   i_0_ack    in   downstream takes the word
//   en0, en1   out  load datapath register 0 / 1 (combinational)
//   sel        out  datapath output select, 0 = reg 0, 1 = reg 1 (registered)
//   flush      in   synchronous discard of all buffered words
//   stat_clr   in   synchronous clear of stall_cnt
//   occupancy  out  buffered word count 0..2 (registered)
//   stall_cnt  out  saturating count of cycles with i_0_req=1 and i_0_ack=0
module eb2a_ctrl #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 t_0_req,
    output logic                 t_0_ack,
    output logic                 i_0_req,
    input  logic                 i_0_ack,
    output logic                 en0,
    output logic                 en1,
    output logic                 sel,
    input  logic                 flush,
    input  logic                 stat_clr,
    output logic [1:0]           occupancy,
    output logic [CNT_WIDTH-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_HALF  = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic                   r_wp;
    logic                   r_rp;
    logic                   r_t_0_ack;
    logic                   r_i_0_req;
    logic [1:0]             r_occ;
    logic [CNT_WIDTH-1:0]   r_stall;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_stall;

    function automatic logic [1:0] occ_of(input state_t s);
        case (s)
            S_HALF:  occ_of = 2'd1;
            S_FULL:  occ_of = 2'd2;
            default: occ_of = 2'd0;
        endcase
    endfunction

    assign w_push  = t_0_req & r_t_0_ack;
    assign w_pop   = r_i_0_req & i_0_ack;
    assign w_stall = r_i_0_req & ~i_0_ack;

    // A push coincident with flush is discarded, so the datapath must not load.
    assign en0 = w_push & ~r_wp & ~flush;
    assign en1 = w_push &  r_wp & ~flush;

    assign t_0_ack   = r_t_0_ack;
    assign i_0_req   = r_i_0_req;
    assign sel       = r_rp;
    assign occupancy = r_occ;
    assign stall_cnt = r_stall;

    always_comb begin
        w_next = r_state;
        if (flush) begin
            w_next = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: if (w_push) w_next = S_HALF;
                S_HALF: begin
                    if (w_push && !w_pop)      w_next = S_FULL;
                    else if (w_pop && !w_push) w_next = S_EMPTY;
                end
                S_FULL:  if (w_pop) w_next = S_HALF;
                default: w_next = S_EMPTY;
            endcase
        end
    end

    // Handshake outputs are registered from the next state so they are valid
    // right after the edge that changes occupancy. t_0_ack stays low in reset
    // and rises on the first edge after reset is released.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_EMPTY;
            r_wp      <= 1'b0;
            r_rp      <= 1'b0;
            r_t_0_ack <= 1'b0;
            r_i_0_req <= 1'b0;
            r_occ     <= 2'd0;
        end else begin
            r_state   <= w_next;
            r_t_0_ack <= (w_next != S_FULL);
            r_i_0_req <= (w_next != S_EMPTY);
            r_occ     <= occ_of(w_next);
            if (flush) begin
                r_wp <= 1'b0;
                r_rp <= 1'b0;
            end else begin
                if (w_push) r_wp <= ~r_wp;
                if (w_pop)  r_rp <= ~r_rp;
            end
        end
    end

    // Stall statistics: saturating, clear wins, unaffected by flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall <= '0;
        end else if (stat_clr) begin
            r_stall <= '0;
        end else if (w_stall && (r_stall != {CNT_WIDTH{1'b1}})) begin
            r_stall <= r_stall + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_eb2a_ctrl.sv
module tb_eb2a_ctrl;

    logic       clk;
    logic       reset;
    logic       t_0_req;
    logic       t_0_ack;
    logic       i_0_req;
    logic       i_0_ack;
    logic       en0;
    logic       en1;
    logic       sel;
    logic       flush;
    logic       stat_clr;
    logic [1:0] occupancy;
    logic [3:0] stall_cnt;

    // Behavioural two-register datapath driven by the controller.
    logic [7:0] din;
    logic [7:0] reg0;
    logic [7:0] reg1;
    logic [7:0] dout;

    int checks;
    int errors;

    eb2a_ctrl #(.CNT_WIDTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .t_0_req   (t_0_req),
        .t_0_ack   (t_0_ack),
        .i_0_req   (i_0_req),
        .i_0_ack   (i_0_ack),
        .en0       (en0),
        .en1       (en1),
        .sel       (sel),
        .flush     (flush),
        .stat_clr  (stat_clr),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (en0) reg0 <= din;
        if (en1) reg1 <= din;
    end
    assign dout = sel ? reg1 : reg0;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; t_0_req = 1'b0; i_0_ack = 1'b0; flush = 1'b0;
        stat_clr = 1'b0; din = 8'h00;
        step(); step();
        checks++; if (t_0_ack !== 1'b0) begin errors++; $display("FAIL rst_t_ack got %0b exp 0", t_0_ack); end
        checks++; if (i_0_req !== 1'b0) begin errors++; $display("FAIL rst_i_req got %0b exp 0", i_0_req); end
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL rst_occ got %0d exp 0", occupancy); end
        checks++; if (sel !== 1'b0) begin errors++; $display("FAIL rst_sel got %0b exp 0", sel); end
        checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL rst_stall got %0d exp 0", stall_cnt); end
        t_0_req = 1'b1; #1;
        checks++; if ({en0, en1} !== 2'b00) begin errors++; $display("FAIL rst_en got %0b%0b exp 00", en0, en1); end
        t_0_req = 1'b0;
        reset = 1'b0;
        step();
        checks++; if (t_0_ack !== 1'b1) begin errors++; $display("FAIL rel_t_ack got %0b exp 1", t_0_ack); end
        checks++; if (i_0_req !== 1'b0) begin errors++; $display("FAIL rel_i_req got %0b exp 0", i_0_req); end
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL rel_occ got %0d exp 0", occupancy); end
        // One word in flight, then asynchronous reset between edges.
        t_0_req = 1'b1; din = 8'h55;
        step();
        t_0_req = 1'b0;
        checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL mid_occ_pre got %0d exp 1", occupancy); end
        #2 reset = 1'b1;
        #1;
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL async_occ got %0d exp 0", occupancy); end
        checks++; if (i_0_req !== 1'b0) begin errors++; $display("FAIL async_i_req got %0b exp 0", i_0_req); end
        checks++; if (t_0_ack !== 1'b0) begin errors++; $display("FAIL async_t_ack got %0b exp 0", t_0_ack); end
        reset = 1'b0;
        step();
        checks++; if (t_0_ack !== 1'b1) begin errors++; $display("FAIL rel2_t_ack got %0b exp 1", t_0_ack); end
    endtask

    task automatic test_streaming();
        i_0_ack = 1'b1;
        t_0_req = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            din = 8'(k);
            #1;
            checks++; if (en0 !== k[0]) begin errors++; $display("FAIL str_en0 k=%0d got %0b exp %0b", k, en0, k[0]); end
            checks++; if (en1 !== ~k[0]) begin errors++; $display("FAIL str_en1 k=%0d got %0b exp %0b", k, en1, ~k[0]); end
            if (k > 1) begin
                checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL str_occ k=%0d got %0d exp 1", k, occupancy); end
                checks++; if (dout !== 8'(k - 1)) begin errors++; $display("FAIL str_data k=%0d got %0d exp %0d", k, dout, k - 1); end
                checks++; if (t_0_ack !== 1'b1) begin errors++; $display("FAIL str_t_ack k=%0d got %0b exp 1", k, t_0_ack); end
            end
            step();
        end
        t_0_req = 1'b0;
        #1;
        checks++; if (i_0_req !== 1'b1) begin errors++; $display("FAIL str_last_req got %0b exp 1", i_0_req); end
        checks++; if (dout !== 8'd8) begin errors++; $display("FAIL str_last_data got %0d exp 8", dout); end
        step();
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL str_drain_occ got %0d exp 0", occupancy); end
        checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL str_stall got %0d exp 0", stall_cnt); end
    endtask

    task automatic test_backpressure();
        i_0_ack = 1'b0;
        t_0_req = 1'b1; din = 8'hA1;
        step();
        din = 8'hB2;
        step();
        din = 8'hC3;
        #1;
        checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL bp_occ got %0d exp 2", occupancy); end
        checks++; if (t_0_ack !== 1'b0) begin errors++; $display("FAIL bp_t_ack got %0b exp 0", t_0_ack); end
        checks++; if ({en0, en1} !== 2'b00) begin errors++; $display("FAIL bp_en got %0b%0b exp 00", en0, en1); end
        checks++; if (dout !== 8'hA1) begin errors++; $display("FAIL bp_head got %0h exp a1", dout); end
        step();
        checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL bp_hold_occ got %0d exp 2", occupancy); end
        checks++; if (stall_cnt !== 4'd2) begin errors++; $display("FAIL bp_stall_mid got %0d exp 2", stall_cnt); end
        i_0_ack = 1'b1;
        #1;
        checks++; if (dout !== 8'hA1) begin errors++; $display("FAIL bp_popA got %0h exp a1", dout); end
        step();
        #1;
        checks++; if (t_0_ack !== 1'b1) begin errors++; $display("FAIL bp_reopen got %0b exp 1", t_0_ack); end
        checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL bp_occ1 got %0d exp 1", occupancy); end
        checks++; if (dout !== 8'hB2) begin errors++; $display("FAIL bp_popB got %0h exp b2", dout); end
        checks++; if (en0 !== 1'b1) begin errors++; $display("FAIL bp_enC got %0b exp 1", en0); end
        step();
        t_0_req = 1'b0;
        #1;
        checks++; if (dout !== 8'hC3) begin errors++; $display("FAIL bp_popC got %0h exp c3", dout); end
        step();
        checks++; if (i_0_req !== 1'b0) begin errors++; $display("FAIL bp_empty got %0b exp 0", i_0_req); end
        checks++; if (stall_cnt !== 4'd2) begin errors++; $display("FAIL bp_stall got %0d exp 2", stall_cnt); end
    endtask

    task automatic test_flush();
        i_0_ack = 1'b0;
        t_0_req = 1'b1; din = 8'h11;
        step();
        din = 8'h22;
        step();
        // stall count was 2, one stalled edge while holding Y -> 3
        checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL fl_pre_occ got %0d exp 2", occupancy); end
        checks++; if (stall_cnt !== 4'd3) begin errors++; $display("FAIL fl_pre_stall got %0d exp 3", stall_cnt); end
        flush = 1'b1; i_0_ack = 1'b1; din = 8'h33;
        step();
        // t_0_ack reopened after flush; check the enables while flush is still high
        checks++; if (t_0_ack !== 1'b1) begin errors++; $display("FAIL fl_t_ack got %0b exp 1", t_0_ack); end
        checks++; if ({en0, en1} !== 2'b00) begin errors++; $display("FAIL fl_en got %0b%0b exp 00", en0, en1); end
        flush = 1'b0; t_0_req = 1'b0;
        step();
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL fl_occ got %0d exp 0", occupancy); end
        checks++; if (i_0_req !== 1'b0) begin errors++; $display("FAIL fl_i_req got %0b exp 0", i_0_req); end
        checks++; if (sel !== 1'b0) begin errors++; $display("FAIL fl_sel got %0b exp 0", sel); end
        checks++; if (stall_cnt !== 4'd3) begin errors++; $display("FAIL fl_stall got %0d exp 3", stall_cnt); end
        i_0_ack = 1'b0; t_0_req = 1'b1; din = 8'h44;
        #1;
        checks++; if (en0 !== 1'b1) begin errors++; $display("FAIL fl_post_en0 got %0b exp 1", en0); end
        step();
        t_0_req = 1'b0;
        checks++; if (dout !== 8'h44) begin errors++; $display("FAIL fl_post_data got %0h exp 44", dout); end
        i_0_ack = 1'b1;
        step();
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL fl_post_occ got %0d exp 0", occupancy); end
    endtask

    task automatic test_saturation();
        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
        checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL sat_clr0 got %0d exp 0", stall_cnt); end
        i_0_ack = 1'b0; t_0_req = 1'b1; din = 8'h5A;
        step();
        t_0_req = 1'b0;
        repeat (14) step();
        checks++; if (stall_cnt !== 4'd14) begin errors++; $display("FAIL sat_14 got %0d exp 14", stall_cnt); end
        step();
        checks++; if (stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_15 got %0d exp 15", stall_cnt); end
        repeat (5) step();
        checks++; if (stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_hold got %0d exp 15", stall_cnt); end
        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
        checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL sat_clr got %0d exp 0", stall_cnt); end
        step();
        checks++; if (stall_cnt !== 4'd1) begin errors++; $display("FAIL sat_resume1 got %0d exp 1", stall_cnt); end
        step();
        checks++; if (stall_cnt !== 4'd2) begin errors++; $display("FAIL sat_resume2 got %0d exp 2", stall_cnt); end
        checks++; if (dout !== 8'h5A) begin errors++; $display("FAIL sat_data got %0h exp 5a", dout); end
        i_0_ack = 1'b1;
        step();
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL sat_drain got %0d exp 0", occupancy); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
